// File: rtl/round_ctrl_if.sv
// Round controller handshake bundle: start/target/key in, status and verdict out.
interface round_ctrl_if #(
    parameter int unsigned KEY_WIDTH = 4
);
    logic                 i_start;
    logic [KEY_WIDTH-1:0] i_target;
    logic [KEY_WIDTH-1:0] i_key;
    logic                 o_busy;
    logic                 o_show_target;
    logic [KEY_WIDTH-1:0] o_target;
    logic                 o_round_ended;
    logic                 o_is_win;

    modport master (
        output i_start, i_target, i_key,
        input  o_busy, o_show_target, o_target, o_round_ended, o_is_win
    );

    modport slave (
        input  i_start, i_target, i_key,
        output o_busy, o_show_target, o_target, o_round_ended, o_is_win
    );
endinterface

// File: rtl/round_ctrl.sv
// Per-round game controller: show target, wait for a key press edge or timeout, judge.
// Optional ROUND_CTRL_FALSE_START_EN: a press edge during SHOW ends the round as a loss.
module round_ctrl #(
    parameter int unsigned KEY_WIDTH      = 4,
    parameter int unsigned SHOW_CYCLES    = 200,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input logic         clk,
    input logic         rst_n,
    round_ctrl_if.slave bus
);
    localparam int unsigned MaxCycles =
        (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] ShowLast = CntW'(SHOW_CYCLES - 1);
    localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT_CYCLES - 1);

`ifdef ROUND_CTRL_FALSE_START_EN
    localparam bit FalseStartEn = 1'b1;
`else
    localparam bit FalseStartEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StShow, StWait, StDone} state_e;

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    logic [KEY_WIDTH-1:0] key_prev_q;
    logic [KEY_WIDTH-1:0] target_q;
    logic                 busy_q;
    logic                 show_q;
    logic                 ended_q;
    logic                 win_q;
    logic                 press;

    // Rising edge of "any key down"; a key held across a state change never re-triggers.
    assign press = (bus.i_key != '0) && (key_prev_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            key_prev_q <= '0;
            target_q   <= '0;
            busy_q     <= 1'b0;
            show_q     <= 1'b0;
            ended_q    <= 1'b0;
            win_q      <= 1'b0;
        end else begin
            key_prev_q <= bus.i_key;
            ended_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.i_start) begin
                        state_q  <= StShow;
                        target_q <= bus.i_target;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        show_q   <= 1'b1;
                    end
                end
                StShow: begin
                    if (FalseStartEn && press) begin
                        state_q <= StDone;
                        cnt_q   <= '0;
                        show_q  <= 1'b0;
                        ended_q <= 1'b1;
                        win_q   <= 1'b0;
                    end else if (cnt_q == ShowLast) begin
                        state_q <= StWait;
                        cnt_q   <= '0;
                        show_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWait: begin
                    if (press) begin
                        state_q <= StDone;
                        cnt_q   <= '0;
                        ended_q <= 1'b1;
                        // A zero target can never match because a press needs a nonzero key.
                        win_q   <= (bus.i_key == target_q);
                    end else if (cnt_q == WaitLast) begin
                        state_q <= StDone;
                        cnt_q   <= '0;
                        ended_q <= 1'b1;
                        win_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    show_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy        = busy_q;
    assign bus.o_show_target = show_q;
    assign bus.o_target      = target_q;
    assign bus.o_round_ended = ended_q;
    assign bus.o_is_win      = win_q;
endmodule

// File: doc/round_ctrl.md
# round_ctrl

Per-round game controller sitting directly upstream of the rating stage. On a start request it latches a target key code, shows it for a fixed window, waits for the player's key press or a timeout, and judges the round. It then produces the single-cycle `o_round_ended` strobe and the `o_is_win` verdict that the rating counter consumes.

## Interface
Parameters:
- `KEY_WIDTH`, 4: width of the target code and the key bus.
- `SHOW_CYCLES`, 200: number of cycles the target is displayed; must be ≥1.
- `TIMEOUT_CYCLES`, 1000: length of the answer window in cycles; must be ≥1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `i_start`  in  1  start-round request; honoured only in IDLE.
- `i_target`  in  KEY_WIDTH  target code; sampled in the cycle `i_start` is accepted.
- `i_key`  in  KEY_WIDTH  key level bus, already synchronised and debounced; nonzero means pressed.
- `o_busy`  out  1  high in every state except IDLE.
- `o_show_target`  out  1  high during SHOW.
- `o_target`  out  KEY_WIDTH  latched target; valid while `o_busy`.
- `o_round_ended`  out  1  one-cycle strobe at the end of the round.
- `o_is_win`  out  1  verdict; valid with `o_round_ended` and held until the next strobe.

## Operation
- FSM states: IDLE, SHOW, WAIT, DONE.
- IDLE → SHOW: on `i_start`. `i_target` is latched into `o_target` and the cycle counter is cleared.
- SHOW: lasts exactly SHOW_CYCLES cycles, then moves to WAIT with the counter cleared.
- Press event: `i_key != 0` while the registered previous `i_key` is 0 (rising edge).
  - A key already held when WAIT is entered generates no event until it is released and pressed again.
- WAIT: a press event ends the round.
  - Win iff `i_key == o_target` (exact equality).
  - A multi-key press or a wrong key is a loss.
  - A target of 0 can never be won.
- WAIT timeout: if no press event occurs within TIMEOUT_CYCLES cycles, the round is a loss.
  - A press in the final WAIT cycle beats the timeout.
- DONE: lasts one cycle.
  - `o_round_ended` = 1 and `o_is_win` = verdict, both registered.
  - Next state is IDLE.
- `o_is_win` updates only when entering DONE; it is otherwise stable.
- `i_start` outside IDLE is ignored and is not queued.
- Counter width is `$clog2(max(SHOW_CYCLES, TIMEOUT_CYCLES)+1)`. It is cleared on every state entry and never wraps.
- The previous-key register updates every cycle in every state.

## Timing
- Reset values: state IDLE; counter 0; previous key 0.
  - All outputs are 0: `o_busy`, `o_show_target`, `o_target`, `o_round_ended`, `o_is_win`.
- Reset asserted mid-round aborts immediately: no `o_round_ended` is emitted and `o_is_win` is cleared.
- `i_start` accepted in cycle t:
  - SHOW occupies t+1 … t+SHOW_CYCLES.
  - WAIT starts at t+SHOW_CYCLES+1.
- Press event in WAIT cycle w: DONE (strobe) in cycle w+1.
- Timeout: WAIT occupies W … W+TIMEOUT_CYCLES−1, and DONE is W+TIMEOUT_CYCLES.
- Earliest next accepted `i_start` is the cycle after DONE. Back-to-back rounds therefore have a 1-cycle IDLE minimum.
- No combinational path from inputs to outputs.

## Configuration
- `ROUND_CTRL_FALSE_START_EN` defined:
  - A press event during SHOW ends the round as a loss.
  - DONE follows in the next cycle and the remainder of SHOW is skipped.
- `ROUND_CTRL_FALSE_START_EN` undefined:
  - Presses during SHOW are ignored.
  - A key still held at WAIT entry is ignored until released and re-pressed, per the edge rule.

## Test plan
All scenarios use KEY_WIDTH=4, SHOW_CYCLES=4, TIMEOUT_CYCLES=8, with `i_start` and `i_target` asserted at cycle 0.
- Win: target 4'b0100; press 4'b0100 at cycle 7 → SHOW cycles 1–4; `o_round_ended`=1 and `o_is_win`=1 at cycle 8; `o_busy`=0 at cycle 9.
- Wrong key: target 4'b0100; press 4'b0010 at cycle 6 → strobe at cycle 7 with `o_is_win`=0. A multi-key press of 4'b0110 gives the same result.
- Timeout: no press → WAIT cycles 5–12; strobe at 13 with `o_is_win`=0. A correct press at cycle 12 instead gives a win at 13.
- Held key / false start: hold 4'b0100 from cycle 2.
  - Macro undefined → no event; timeout loss at 13.
  - Macro defined → strobe at 3, loss.
- Busy and reset: pulse `i_start` with target 4'b0001 at cycle 3 → ignored, `o_target` stays 4'b0100. Assert `rst_n`=0 at cycle 6 → all outputs 0 and no strobe; after release a new start works normally.
- `o_is_win` hold: a win round followed by a loss round → `o_is_win` stays 1 until the second strobe, then reads 0.
